// File: rtl/tmds_pkg.sv
// Shared TMDS definitions: control-token constants, aligner state encoding and
// token decode helpers used by both the word aligner and the TMDS decoder.
package tmds_pkg;

  localparam logic [9:0] CTRL_TOKEN_00 = 10'h354;
  localparam logic [9:0] CTRL_TOKEN_01 = 10'h0AB;
  localparam logic [9:0] CTRL_TOKEN_10 = 10'h154;
  localparam logic [9:0] CTRL_TOKEN_11 = 10'h2AB;

  typedef enum logic [1:0] {
    ST_SEARCH = 2'd0,
    ST_VERIFY = 2'd1,
    ST_LOCKED = 2'd2
  } align_state_e;

  function automatic logic is_ctrl_token(input logic [9:0] w);
    return (w == CTRL_TOKEN_00) || (w == CTRL_TOKEN_01) ||
           (w == CTRL_TOKEN_10) || (w == CTRL_TOKEN_11);
  endfunction

  // {C1,C0} of a control token; 0 for any other symbol.
  function automatic logic [1:0] ctrl_code_of(input logic [9:0] w);
    case (w)
      CTRL_TOKEN_01: return 2'b01;
      CTRL_TOKEN_10: return 2'b10;
      CTRL_TOKEN_11: return 2'b11;
      default:       return 2'b00;
    endcase
  endfunction

endpackage

// File: rtl/tmds_bit_select.sv
// Picks a 10-bit candidate symbol out of a 20-bit two-word window at a given
// bit offset. Offsets above 9 fall back to offset 0.
module tmds_bit_select (
  input  logic [19:0] window,
  input  logic [3:0]  offset,
  output logic [9:0]  candidate
);

  logic [9:0][9:0] cand_arr;

  for (genvar o = 0; o < 10; o++) begin : g_off
    assign cand_arr[o] = window[o+9:o];
  end

  always_comb begin
    candidate = cand_arr[0];
    if (offset <= 4'd9) candidate = cand_arr[offset];
  end

endmodule

// File: rtl/tmds_word_aligner.sv
// Per-channel TMDS symbol aligner: hunts for runs of control tokens at each of
// the ten bit offsets, then tracks lock and delivers aligned symbols.
module tmds_word_aligner
  import tmds_pkg::*;
#(
  parameter int TOKEN_COUNT   = 8,
  parameter int SEARCH_WINDOW = 2048
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [9:0] raw_in,
  input  logic       raw_valid,
  output logic [9:0] word_out,
  output logic       word_valid,
  output logic       ctrl_token,
  output logic [1:0] ctrl_code,
  output logic       locked,
  output logic [3:0] slip_pos
);

  localparam int MW = $clog2(SEARCH_WINDOW);
  localparam int RW = $clog2(TOKEN_COUNT + 1);
  localparam logic [MW-1:0] MISS_LIM = MW'(SEARCH_WINDOW - 1);
  localparam logic [RW-1:0] RUN_LIM  = RW'(TOKEN_COUNT);

  align_state_e    state, state_nxt;
  logic [MW-1:0]   miss, miss_nxt, miss_inc;
  logic [RW-1:0]   run, run_nxt, run_inc;
  logic [3:0]      slip_nxt;
  logic [9:0]      prev, cand;
  logic            tok, miss_hit, run_full;

  tmds_bit_select u_sel (
    .window    ({raw_in, prev}),
    .offset    (slip_pos),
    .candidate (cand)
  );

  assign tok      = is_ctrl_token(cand);
  assign miss_hit = (miss == MISS_LIM);
  assign miss_inc = miss_hit ? miss : miss + MW'(1);
  assign run_inc  = (run == RUN_LIM) ? run : run + RW'(1);
  assign run_full = (run_inc == RUN_LIM);

  // A token always beats an expiring miss counter on the same word.
  always_comb begin
    state_nxt = state;
    miss_nxt  = miss;
    run_nxt   = run;
    slip_nxt  = slip_pos;
    case (state)
      ST_SEARCH: begin
        if (tok) begin
          state_nxt = ST_VERIFY;
          run_nxt   = RW'(1);
          miss_nxt  = '0;
        end else if (miss_hit) begin
          slip_nxt = (slip_pos == 4'd9) ? 4'd0 : slip_pos + 4'd1;
          miss_nxt = '0;
        end else begin
          miss_nxt = miss_inc;
        end
      end
      ST_VERIFY: begin
        if (tok) begin
          run_nxt = run_inc;
          if (run_full) begin
            state_nxt = ST_LOCKED;
            miss_nxt  = '0;
          end
        end else begin
          state_nxt = ST_SEARCH;
          run_nxt   = '0;
          miss_nxt  = '0;
        end
      end
      ST_LOCKED: begin
        if (tok) begin
          run_nxt  = run_inc;
          miss_nxt = run_full ? '0 : miss_inc;
        end else begin
          run_nxt = '0;
          if (miss_hit) begin
            state_nxt = ST_SEARCH;
            miss_nxt  = '0;
          end else begin
            miss_nxt = miss_inc;
          end
        end
      end
      default: begin
        state_nxt = ST_SEARCH;
        run_nxt   = '0;
        miss_nxt  = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= ST_SEARCH;
      miss     <= '0;
      run      <= '0;
      slip_pos <= 4'd0;
      prev     <= 10'd0;
    end else if (raw_valid) begin
      state    <= state_nxt;
      miss     <= miss_nxt;
      run      <= run_nxt;
      slip_pos <= slip_nxt;
      prev     <= raw_in;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      word_out   <= 10'd0;
      word_valid <= 1'b0;
      ctrl_token <= 1'b0;
      ctrl_code  <= 2'b00;
      locked     <= 1'b0;
    end else begin
      word_valid <= raw_valid;
      if (raw_valid) begin
        word_out   <= cand;
        ctrl_token <= tok;
        ctrl_code  <= ctrl_code_of(cand);
        locked     <= (state_nxt == ST_LOCKED);
      end
    end
  end

endmodule

// File: tb/tb_tmds_word_aligner.sv
// Directed bench for tmds_word_aligner (TOKEN_COUNT=4, SEARCH_WINDOW=16) with a
// behavioural alignment model checked every cycle plus literal pins.
module tb_tmds_word_aligner;

  localparam int TC = 4;
  localparam int SW = 16;
  localparam logic [9:0] DATA = 10'h0F0;

  logic       clk = 1'b0;
  logic       rst;
  logic [9:0] raw_in;
  logic       raw_valid;
  logic [9:0] word_out;
  logic       word_valid, ctrl_token, locked;
  logic [1:0] ctrl_code;
  logic [3:0] slip_pos;

  int n_cmp = 0;
  int n_err = 0;

  tmds_word_aligner #(.TOKEN_COUNT(TC), .SEARCH_WINDOW(SW)) dut (
    .clk(clk), .rst(rst), .raw_in(raw_in), .raw_valid(raw_valid),
    .word_out(word_out), .word_valid(word_valid), .ctrl_token(ctrl_token),
    .ctrl_code(ctrl_code), .locked(locked), .slip_pos(slip_pos)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [9:0] m_prev = '0, m_word = '0;
  logic       m_vld = 0, m_tok = 0, m_lock = 0;
  logic [1:0] m_code = '0;
  int         m_slip = 0, m_run = 0, m_miss = 0;

  function automatic int tok_code(input logic [9:0] w);
    case (w)
      10'h354: return 0;
      10'h0AB: return 1;
      10'h154: return 2;
      10'h2AB: return 3;
      default: return -1;
    endcase
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_prev <= '0; m_word <= '0; m_vld <= 0; m_tok <= 0; m_code <= '0;
      m_lock <= 0; m_slip <= 0; m_run <= 0; m_miss <= 0;
    end else if (raw_valid) begin
      automatic logic [19:0] win  = {raw_in, m_prev};
      automatic logic [9:0]  cand = 10'((win >> m_slip) & 20'h3FF);
      automatic int          c    = tok_code(cand);
      automatic int          run  = m_run;
      automatic int          miss = m_miss;
      automatic int          slip = m_slip;
      automatic logic        lk   = m_lock;
      if (c >= 0) begin
        run = (run < TC) ? run + 1 : TC;
        if (!lk) begin
          if (run == 1) miss = 0;
          if (run == TC) begin lk = 1; miss = 0; end
        end else begin
          miss = (run == TC) ? 0 : ((miss < SW - 1) ? miss + 1 : SW - 1);
        end
      end else if (!lk && run > 0) begin
        run = 0; miss = 0;
      end else begin
        run = 0;
        if (miss == SW - 1) begin
          miss = 0;
          if (lk) lk = 0;
          else slip = (slip + 1) % 10;
        end else miss = miss + 1;
      end
      m_prev <= raw_in;
      m_word <= cand;
      m_tok  <= (c >= 0);
      m_code <= (c >= 0) ? 2'(c) : 2'b00;
      m_vld  <= 1;
      m_lock <= lk;
      m_run  <= run;
      m_miss <= miss;
      m_slip <= slip;
    end else begin
      m_vld <= 0;
    end
  end

  always @(negedge clk) begin
    chk("word_out",   32'(word_out),   32'(m_word));
    chk("word_valid", 32'(word_valid), 32'(m_vld));
    chk("ctrl_token", 32'(ctrl_token), 32'(m_tok));
    chk("ctrl_code",  32'(ctrl_code),  32'(m_code));
    chk("locked",     32'(locked),     32'(m_lock));
    chk("slip_pos",   32'(slip_pos),   32'(m_slip));
  end

  // ---------------- stimulus ----------------
  logic bitq[$];

  task automatic send(input logic [9:0] w);
    raw_in = w; raw_valid = 1'b1;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    raw_valid = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    raw_valid = 1'b0;
    #2 rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic push_sym(input logic [9:0] s);
    for (int i = 0; i < 10; i++) bitq.push_back(s[i]);
  endtask

  task automatic pop_word(output logic [9:0] w);
    for (int i = 0; i < 10; i++) w[i] = bitq.pop_front();
  endtask

  initial begin
    logic [9:0] w;
    int k;
    rst = 1'b1; raw_in = '0; raw_valid = 1'b0;
    #1 rst = 1'b0;
    @(negedge clk);

    // reset held with random traffic
    for (int i = 0; i < 5; i++) begin
      raw_in = 10'($urandom); raw_valid = 1'b1;
      @(negedge clk);
      chk("rst_word", 32'(word_out), 0);
      chk("rst_lock", 32'(locked), 0);
      chk("rst_slip", 32'(slip_pos), 0);
      chk("rst_vld",  32'(word_valid), 0);
    end
    raw_valid = 1'b0;
    rst = 1'b1;

    // mid-VERIFY asynchronous reset
    repeat (3) send(10'h154);
    chk("pre_rst_word", 32'(word_out), 32'h154);
    raw_valid = 1'b0;
    #2 rst = 1'b0;
    #1;
    chk("async_word", 32'(word_out), 0);
    chk("async_tok",  32'(ctrl_token), 0);
    chk("async_code", 32'(ctrl_code), 0);
    @(negedge clk);
    rst = 1'b1;
    repeat (3) send(10'h154);
    send(DATA);
    chk("run_cleared_lock", 32'(locked), 0);

    // aligned stream, 4 x 0x354
    do_reset();
    repeat (4) send(10'h354);
    chk("aln_pre_lock", 32'(locked), 0);
    send(DATA);
    chk("aln_lock", 32'(locked), 1);
    chk("aln_word", 32'(word_out), 32'h354);
    chk("aln_code", 32'(ctrl_code), 0);
    repeat (2) send(DATA);
    idle(1);
    chk("aln_idle_vld", 32'(word_valid), 0);
    chk("aln_idle_lock", 32'(locked), 1);

    // stream shifted by 3 bits, then lock loss and re-lock
    do_reset();
    bitq.delete();
    repeat (3) bitq.push_back(1'b0);
    for (int p = 0; p < 5; p++) begin
      repeat (16) push_sym(DATA);
      repeat (4) push_sym(10'h2AB);
    end
    k = 0;
    while (bitq.size() >= 10) begin
      pop_word(w);
      send(w);
      case (k)
        14: chk("sh_slip0", 32'(slip_pos), 0);
        15: chk("sh_slip1", 32'(slip_pos), 1);
        31: chk("sh_slip2", 32'(slip_pos), 2);
        47: chk("sh_slip3", 32'(slip_pos), 3);
        59: chk("sh_prelock", 32'(locked), 0);
        60: begin
          chk("sh_lock", 32'(locked), 1);
          chk("sh_word", 32'(word_out), 32'h2AB);
          chk("sh_code", 32'(ctrl_code), 3);
        end
        75: chk("drop_pre", 32'(locked), 1);
        76: begin
          chk("drop_lock", 32'(locked), 0);
          chk("drop_slip", 32'(slip_pos), 3);
        end
        80: chk("relock", 32'(locked), 1);
        default: ;
      endcase
      k++;
    end

    // VERIFY paused by idle cycles
    do_reset();
    repeat (3) send(10'h154);
    idle(5);
    chk("pause_vld", 32'(word_valid), 0);
    chk("pause_word", 32'(word_out), 32'h154);
    send(10'h154);
    chk("pause_prelock", 32'(locked), 0);
    send(DATA);
    chk("pause_lock", 32'(locked), 1);

    // VERIFY broken by a data word
    do_reset();
    send(10'h0AB); send(10'h0AB); send(DATA); send(DATA);
    chk("brk_lock", 32'(locked), 0);
    chk("brk_slip", 32'(slip_pos), 0);
    repeat (4) send(10'h0AB);
    send(DATA);
    chk("brk_relock", 32'(locked), 1);
    chk("brk_code", 32'(ctrl_code), 1);

    // slip wrap 9 -> 0, then token on the miss-limit word
    do_reset();
    for (int i = 0; i < 160; i++) begin
      send(DATA);
      if (i == 142) chk("wrap_s8", 32'(slip_pos), 8);
      if (i == 143) chk("wrap_s9", 32'(slip_pos), 9);
      if (i == 159) chk("wrap_s0", 32'(slip_pos), 0);
    end
    repeat (14) send(DATA);
    repeat (4) send(10'h354);
    chk("lim_slip", 32'(slip_pos), 0);
    chk("lim_lock", 32'(locked), 0);
    send(DATA);
    chk("lim_lock_after", 32'(locked), 1);
    chk("lim_slip_after", 32'(slip_pos), 0);

    idle(2);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
